// File: rtl/mod_shiftrows_buffer_if.sv
// Handshake bundle for mod_shiftrows_buffer: element input side, block output side, flush.
interface mod_shiftrows_buffer_if #(
    parameter int DW   = 8,
    parameter int NROW = 4,
    parameter int NCOL = 4
);
    localparam int NB = NROW * NCOL;
    localparam int CW = $clog2(NB);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              in_inv;
    logic              out_valid;
    logic              out_ready;
    logic [NB*DW-1:0]  out_data;
    logic              out_inv;
    logic [CW-1:0]     byte_cnt;

    modport master (
        output flush, in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_inv, byte_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_inv, byte_cnt
    );
endinterface

// File: rtl/mod_shiftrows_buffer.sv
// Byte-serial state collector presenting a ShiftRows/InvShiftRows-permuted block.
// Define SHF_PINGPONG_EN for a two-bank buffer that streams blocks with no bubble.
module mod_shiftrows_buffer #(
    parameter int DW   = 8,
    parameter int NROW = 4,
    parameter int NCOL = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    mod_shiftrows_buffer_if.slave bus
);
    localparam int NB = NROW * NCOL;
    localparam int CW = $clog2(NB);

    logic          in_fire;
    logic          wr_en;
    logic          last_elem;
    logic          rd_mode;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign in_fire      = bus.in_valid & bus.in_ready;
    // flush wins over a coincident element write
    assign wr_en        = in_fire & ~bus.flush;
    assign last_elem    = (cnt_q == CW'(NB - 1));
    assign bus.byte_cnt = cnt_q;
    assign rd_mode      = bus.out_inv;

`ifdef SHF_PINGPONG_EN
    logic       out_fire;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] full_q;
    logic [1:0] mode_q;

    assign out_fire      = bus.out_valid & bus.out_ready;
    assign bus.in_ready  = ~full_q[wr_ptr_q];
    assign bus.out_valid = full_q[rd_ptr_q];
    assign bus.out_inv   = mode_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (bus.flush) begin
            cnt_d = '0;
        end else if (wr_en) begin
            cnt_d = last_elem ? '0 : cnt_q + CW'(1);
        end
    end

    // A bank being written is never full, so a completing write and a read
    // in the same cycle always touch different banks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q   <= '0;
            mode_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (bus.flush) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (wr_en && cnt_q == '0) begin
                mode_q[wr_ptr_q] <= bus.in_inv;
            end
            if (wr_en && last_elem) begin
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (out_fire) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
            end
        end
    end
`else
    typedef enum logic {LOAD, FULL} state_t;

    state_t state_q;
    state_t state_d;
    logic   mode_q;

    assign bus.out_inv = mode_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOAD;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en && cnt_q == '0) begin
                mode_q <= bus.in_inv;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (last_elem) begin
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        if (bus.flush) begin
            state_d = LOAD;
            cnt_d   = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_elem
        logic [DW-1:0] rd;
`ifdef SHF_PINGPONG_EN
        logic [DW-1:0] q [2];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                q[0] <= '0;
                q[1] <= '0;
            end else if (wr_en && cnt_q == CW'(gi)) begin
                q[wr_ptr_q] <= bus.in_data;
            end
        end
        assign rd = q[rd_ptr_q];
`else
        logic [DW-1:0] q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                q <= '0;
            end else if (wr_en && cnt_q == CW'(gi)) begin
                q <= bus.in_data;
            end
        end
        assign rd = q;
`endif
    end

    // Row r rotates left by r (forward) or right by r (inverse), modulo NCOL.
    for (genvar gi = 0; gi < NB; gi++) begin : g_perm
        localparam int R  = gi / NCOL;
        localparam int C  = gi % NCOL;
        localparam int SF = R * NCOL + (C + R) % NCOL;
        localparam int SI = R * NCOL + (C + NCOL - (R % NCOL)) % NCOL;
        assign bus.out_data[gi*DW +: DW] = rd_mode ? g_elem[SI].rd : g_elem[SF].rd;
    end
endmodule
